// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the clock-divider controller.
// The optional forced-switch timeout is enabled by defining CLKDIV_CTRL_TIMEOUT_EN.
package clkdiv_pkg;

  localparam int DIV_W       = 3;
  localparam int CNT_W       = 7;
  localparam int TIMEOUT_CYC = 256;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  // Terminal count for a divide select d: 2^d - 1 (half-period of 2^d clk cycles).
  function automatic logic [CNT_W-1:0] tc_of(input logic [DIV_W-1:0] div);
    logic [CNT_W:0] one_hot;
    one_hot = {{CNT_W{1'b0}}, 1'b1} << div;
    return one_hot[CNT_W-1:0] - {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/clkdiv_core.sv
// Divider datapath: half-period counter, terminal-count decode, clk_out toggle,
// and a load port that restarts the divider at a new select with clk_out low.
module clkdiv_core
  import clkdiv_pkg::*;
#(
  parameter logic [DIV_W-1:0] DIV_RST = 3'd0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             clk_out,
  output logic [DIV_W-1:0] cur_div,
  output logic             at_tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;

  assign at_tc   = (cnt_q == tc_of(cur_div_q));
  assign clk_out = clk_out_q;
  assign cur_div = cur_div_q;

  // Next-state: a load wins over counting; counting only advances while enabled.
  always_comb begin
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    cur_div_d = cur_div_q;
    if (load) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      cur_div_d = load_div;
    end else if (en) begin
      if (at_tc) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Divider registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      cur_div_q <= DIV_RST;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      cur_div_q <= cur_div_d;
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Clock-divider controller: accepts divide-select requests and switches the
// divider only at a clean clk_out falling boundary (or while frozen low), so
// no runt phase is ever produced.
// Optional: CLKDIV_CTRL_TIMEOUT_EN forces the switch after the divider has
// been frozen high for TIMEOUT_CYC consecutive pending cycles, flagging err.
//
// state | meaning
// IDLE  | ready for a request; divider runs at cur_div
// PEND  | new select captured; waiting for a safe switch point
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter logic [DIV_W-1:0] DIV_RST = 3'd0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             en,
  input  logic             req_valid,
  input  logic [DIV_W-1:0] req_div,
  output logic             req_ready,
  output logic             clk_out,
  output logic [DIV_W-1:0] cur_div,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             done_q, done_d;
  logic             load, at_tc, hold, to_fire;

  clkdiv_core #(.DIV_RST(DIV_RST)) u_core (
    .clk      (clk),
    .rst_     (rst_),
    .en       (en),
    .load     (load),
    .load_div (pend_div_q),
    .clk_out  (clk_out),
    .cur_div  (cur_div),
    .at_tc    (at_tc)
  );

  // Divider stuck high with the request pending: only the timeout can resolve it.
  assign hold = (state_q == PEND) && !en && clk_out;

`ifdef CLKDIV_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
  assign to_fire  = hold && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  assign to_cnt_d = hold ? to_cnt_q + 1'b1 : '0;
  assign err_d    = to_fire;
  assign err      = err_q;
`else
  assign to_fire = 1'b0;
  assign err     = 1'b0;
`endif

  // Request handshake and switch-point selection.
  always_comb begin
    state_d    = state_q;
    pend_div_d = pend_div_q;
    done_d     = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          pend_div_d = req_div;
          if (req_div == cur_div) done_d  = 1'b1;
          else                    state_d = PEND;
        end
      end
      PEND: begin
        if ((en && at_tc && clk_out) || (!en && !clk_out) || to_fire) begin
          load    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      pend_div_q <= DIV_RST;
      done_q     <= 1'b0;
`ifdef CLKDIV_CTRL_TIMEOUT_EN
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pend_div_q <= pend_div_d;
      done_q     <= done_d;
`ifdef CLKDIV_CTRL_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: per-cycle vector table from reset,
// directed switch-point sequences, then random traffic against a
// remaining-phase-length reference model.
module tb_clkdiv_ctrl;
  import clkdiv_pkg::*;

  localparam logic [2:0] DRST = 3'd2;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       en = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_div = 3'd0;
  logic       req_ready, clk_out, done, err;
  logic [2:0] cur_div;

  int n_chk = 0;
  int n_fail = 0;

  clkdiv_ctrl #(.DIV_RST(DRST)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .en        (en),
    .req_valid (req_valid),
    .req_div   (req_div),
    .req_ready (req_ready),
    .clk_out   (clk_out),
    .cur_div   (cur_div),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs at a falling edge, return at the next falling edge.
  task automatic step(input logic e, input logic v, input logic [2:0] d);
    en = e; req_valid = v; req_div = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_ = 1'b0; en = 1'b1; req_valid = 1'b0; req_div = 3'd0;
    @(negedge clk); @(negedge clk);
    rst_ = 1'b1;
  endtask

  // Reference model: tracks cycles left in the current clk_out phase.
  bit m_out, m_pend, m_done, m_err;
  int m_left, m_div, m_pdiv, m_to;

  task automatic model_reset();
    m_out = 0; m_pend = 0; m_done = 0; m_err = 0;
    m_div = DRST; m_pdiv = DRST; m_left = 1 << DRST; m_to = 0;
  endtask

  task automatic model_tick();
    m_left--;
    if (m_left == 0) begin
      m_out  = !m_out;
      m_left = 1 << m_div;
    end
  endtask

  task automatic model_step(input bit e, input bit v, input int d);
    bit sw, to_hit;
    sw = 0; to_hit = 0; m_done = 0; m_err = 0;
    if (!m_pend) begin
      if (v) m_pdiv = d;
      if (v && d == m_div) m_done = 1;
      if (e) model_tick();
      if (v && d != m_div) m_pend = 1;
    end else begin
      if (e) begin
        if (m_left == 1 && m_out) sw = 1;
        else model_tick();
      end else if (!m_out) begin
        sw = 1;
      end else begin
`ifdef CLKDIV_CTRL_TIMEOUT_EN
        m_to++;
        if (m_to == TIMEOUT_CYC) begin sw = 1; to_hit = 1; end
`endif
      end
      if (e || !m_out) m_to = 0;
      if (sw) begin
        m_out = 0; m_div = m_pdiv; m_left = 1 << m_div;
        m_done = 1; m_err = to_hit; m_pend = 0; m_to = 0;
      end
    end
  endtask

  typedef struct {
    logic       en, rv;
    logic [2:0] rd;
    logic       out;
    logic [2:0] div;
    logic       dn, rdy;
  } vec_t;

  vec_t tbl[22];

  initial begin
    int n, cnt;
    bit seen_done, seen_err;

    // Cycle-by-cycle from reset release with DIV_RST = 2 (tc = 3).
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b1}; // first rise, 4th edge
    tbl[4]  = '{1'b1, 1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 1'b1}; // same select: done next cycle
    tbl[5]  = '{1'b1, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 1'b1}; // waveform unchanged
    tbl[8]  = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 1'b1}; // frozen
    tbl[9]  = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0}; // PEND
    tbl[12] = '{1'b1, 1'b1, 3'd5, 1'b0, 3'd2, 1'b0, 1'b0}; // ignored in PEND
    tbl[13] = '{1'b1, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0}; // rising: no switch
    tbl[14] = '{1'b1, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1}; // switch at fall
    tbl[18] = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b1};
    tbl[19] = '{1'b1, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b1};
    tbl[20] = '{1'b1, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b1};
    tbl[21] = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b1};

    @(negedge clk);
    rst_ = 1'b0; en = 1'b1;
    #1;
    chk("reset.clk_out", clk_out, 0);
    chk("reset.cur_div", cur_div, DRST);
    chk("reset.done", done, 0);
    chk("reset.err", err, 0);
    chk("reset.req_ready", req_ready, 1);
    @(negedge clk); @(negedge clk);
    rst_ = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].en, tbl[i].rv, tbl[i].rd);
      chk($sformatf("tbl[%0d].clk_out", i), clk_out, tbl[i].out);
      chk($sformatf("tbl[%0d].cur_div", i), cur_div, tbl[i].div);
      chk($sformatf("tbl[%0d].done", i), done, tbl[i].dn);
      chk($sformatf("tbl[%0d].req_ready", i), req_ready, tbl[i].rdy);
      chk($sformatf("tbl[%0d].err", i), err, 0);
    end

    // Move to select 0, then request 3 while clk_out is high.
    step(1, 1, 3'd0);
    n = 0;
    while (!done && n < 10) begin step(1, 0, 0); n++; end
    chk("sel0.done_seen", done, 1);
    chk("sel0.cur_div", cur_div, 0);
    n = 0;
    while (!clk_out && n < 4) begin step(1, 0, 0); n++; end
    chk("sel0.clk_out_high", clk_out, 1);
    step(1, 1, 3'd3);
    chk("up3.last_high_1cyc", clk_out, 0);
    chk("up3.ready_low", req_ready, 0);
    step(1, 0, 0);
    chk("up3.rise_before_switch", clk_out, 1);
    chk("up3.no_early_done", done, 0);
    step(1, 0, 0);
    chk("up3.done", done, 1);
    chk("up3.clk_out_fall", clk_out, 0);
    chk("up3.cur_div", cur_div, 3);
    cnt = 1;
    while (clk_out == 0 && cnt < 20) begin
      step(1, 0, 0);
      if (clk_out == 0) cnt++;
    end
    chk("up3.low_phase_len", cnt, 8);

    // Frozen low while pending: switch on the next cycle.
    n = 0;
    while (clk_out && n < 20) begin step(1, 0, 0); n++; end
    chk("frz_lo.clk_out_low", clk_out, 0);
    step(0, 1, 3'd1);
    chk("frz_lo.ready_low", req_ready, 0);
    chk("frz_lo.no_done_yet", done, 0);
    step(0, 0, 0);
    chk("frz_lo.done", done, 1);
    chk("frz_lo.cur_div", cur_div, 1);
    chk("frz_lo.clk_out", clk_out, 0);
    chk("frz_lo.ready", req_ready, 1);

    // Frozen high while pending.
    n = 0;
    while (!clk_out && n < 10) begin step(1, 0, 0); n++; end
    chk("frz_hi.clk_out_high", clk_out, 1);
    step(0, 1, 3'd4);
    chk("frz_hi.ready_low", req_ready, 0);
`ifdef CLKDIV_CTRL_TIMEOUT_EN
    n = 0;
    for (int k = 1; k <= 300; k++) begin
      step(0, 0, 0);
      if (done) begin n = k; break; end
    end
    chk("timeout.cycles", n, 256);
    chk("timeout.err", err, 1);
    chk("timeout.clk_out", clk_out, 0);
    chk("timeout.cur_div", cur_div, 4);
    step(0, 0, 0);
    chk("timeout.err_pulse", err, 0);
    chk("timeout.done_pulse", done, 0);
`else
    seen_done = 0; seen_err = 0;
    for (int k = 0; k < 300; k++) begin
      step(0, 0, 0);
      if (done) seen_done = 1;
      if (err) seen_err = 1;
    end
    chk("wait.no_done", seen_done, 0);
    chk("wait.no_err", seen_err, 0);
    chk("wait.clk_out_held", clk_out, 1);
    chk("wait.still_pend", req_ready, 0);
    n = 0;
    while (!done && n < 20) begin step(1, 0, 0); n++; end
    chk("wait.resolve_done", done, 1);
    chk("wait.resolve_div", cur_div, 4);
    chk("wait.resolve_clk_out", clk_out, 0);
`endif

    // Reset mid-PEND discards the request.
    step(1, 1, 3'd6);
    chk("rstpend.ready_low", req_ready, 0);
    step(1, 0, 0);
    rst_ = 1'b0;
    #1;
    chk("rstpend.clk_out", clk_out, 0);
    chk("rstpend.cur_div", cur_div, DRST);
    chk("rstpend.ready", req_ready, 1);
    chk("rstpend.done", done, 0);
    @(negedge clk);
    rst_ = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 0);
      if (done) seen_done = 1;
    end
    chk("rstpend.no_done", seen_done, 0);
    chk("rstpend.cur_div_after", cur_div, DRST);
    chk("rstpend.ready_after", req_ready, 1);

    // Random traffic against the model.
    do_reset();
    model_reset();
    for (int k = 0; k < 4000; k++) begin
      bit e, v;
      logic [2:0] d;
      e = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 7) == 0);
      d = 3'($urandom_range(0, 7));
      step(e, v, d);
      model_step(e, v, int'(d));
      chk("rnd.clk_out", clk_out, m_out);
      chk("rnd.cur_div", cur_div, m_div);
      chk("rnd.done", done, m_done);
      chk("rnd.err", err, m_err);
      chk("rnd.req_ready", req_ready, !m_pend);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clkdiv_ctrl.md
CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

Interface
REQ-001 SHALL have parameter DIV_RST, default 3'd0: divider select loaded at reset.
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port rst_  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  divider run enable; counter and clk_out freeze while low.
REQ-005 SHALL have port req_valid  input  1  new divide-select request.
REQ-006 SHALL have port req_div  input  3  requested select d; divide ratio 2^(d+1).
REQ-007 SHALL have port req_ready  output  1  controller can accept a request.
REQ-008 SHALL have port clk_out  output  1  divided clock, 50% duty.
REQ-009 SHALL have port cur_div  output  3  select currently in effect.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a request takes effect.
REQ-011 SHALL have port err  output  1  one-cycle pulse when a switch was forced by timeout.

Function
REQ-012 SHALL keep a 7-bit counter with terminal count tc = 2^cur_div - 1; half-period = 2^cur_div clk cycles.
REQ-013 SHALL, with en high and counter == tc, toggle clk_out and clear counter; otherwise, with en high, increment counter.
REQ-014 SHALL implement FSM states IDLE and PEND; req_ready = 1 only in IDLE.
REQ-015 SHALL, on req_valid && req_ready, capture req_div into pend_div; if pend_div == cur_div, pulse done next cycle and stay IDLE; else go to PEND.
REQ-016 SHALL, in PEND with en high, counter == tc and clk_out == 1, drive clk_out 0, clear counter, load cur_div <= pend_div, pulse done, return to IDLE (switch only at falling boundary).
REQ-017 SHALL, in PEND with en low and clk_out == 0, apply pend_div immediately: clear counter, load cur_div, pulse done, return to IDLE.
REQ-018 SHALL guarantee every clk_out high/low phase lasts exactly the old or the new half-period; no runt phase.
REQ-019 SHALL ignore req_valid while in PEND (no capture, no overwrite of pend_div).
REQ-020 SHALL keep done and err low in all cycles other than those specified.

Reset
REQ-021 SHALL, on rst_ low, immediately set clk_out 0, counter 0, cur_div DIV_RST, state IDLE, pend_div DIV_RST, done 0, err 0, timeout counter 0.
REQ-022 SHALL, on reset during PEND, discard the pending request without done pulse.
REQ-023 SHALL release reset synchronously in effect: first count on first clk edge with rst_ high and en high.

Configuration
REQ-024 SHALL, with CLKDIV_CTRL_TIMEOUT_EN defined, count consecutive PEND cycles with en low and clk_out high; at 256 cycles force clk_out 0, clear counter, load cur_div, pulse done and err together, return to IDLE.
REQ-025 SHALL, without CLKDIV_CTRL_TIMEOUT_EN, wait in PEND indefinitely and tie err to 0; no timeout counter is built.

Structure
REQ-026 SHALL place the FSM state enum, DIV_W = 3, CNT_W = 7 and TIMEOUT_CYC = 256 in shared package clkdiv_pkg.
REQ-027 SHALL instantiate one sub-module clkdiv_core (counter, tc decode, clk_out toggle, load port) controlled by the FSM in clkdiv_ctrl.

Verification
REQ-028 SHALL cover reset with DIV_RST = 2, en = 1 -> clk_out period 8 clk, first rise 4 cycles after reset release.
REQ-029 SHALL cover req_div = 2 while cur_div = 2 -> done one cycle after handshake, clk_out waveform unchanged.
REQ-030 SHALL cover cur_div = 0 -> req_div = 3 issued while clk_out high -> last high phase 1 cycle, next low phase 8 cycles, cur_div = 3 with done on the falling edge.
REQ-031 SHALL cover req_valid held during PEND with req_div = 5 -> ignored; cur_div ends at first request value.
REQ-032 SHALL cover en low with clk_out low in PEND -> switch next cycle; with clk_out high and TIMEOUT_EN -> done and err after 256 cycles, clk_out 0.
REQ-033 SHALL cover rst_ asserted mid-PEND -> no done, cur_div = DIV_RST, req_ready = 1 after release.
